pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready flow control, flush, bubble masking of control fields, optional 2-entry skid buffer and a saturating back-pressure counter. It is the generic successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage boundary instantiates one copy, with the datapath fields concatenated on `in_data` and the control fields on `in_ctrl`.

---
 rtl/pipe_stage_reg.sv | 217 +++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic pipeline stage register placed between two pipeline stages
// (IF/ID, ID/EX, EX/MEM, MEM/WB and similar). Datapath fields travel on
// in_data and control fields on in_ctrl. Entries move with valid/ready
// handshakes, flush kills everything held, and the control field is forced to
// zero whenever no valid entry is presented, so a bubble can never assert
// RegWrite, MemWrite or similar. A saturating counter records how many cycles
// the stage was blocked by downstream.
//
// Parameters
//   DATA_W : datapath payload width
//   CTRL_W : control payload width (masked on bubbles)
//   SKID   : 1 = two-entry skid buffer with registered in_ready,
//            0 = single register with combinational in_ready
//   CNT_W  : width of stall_cycles
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   in_valid     : upstream presents an entry
//   in_ready     : stage accepts this cycle
//   in_data      : datapath payload in
//   in_ctrl      : control payload in
//   flush        : synchronous kill of all held entries
//   out_valid    : stage presents an entry
//   out_ready    : downstream accepts this cycle
//   out_data     : head entry datapath (not masked)
//   out_ctrl     : head entry control, zero when out_valid is low
//   stall_cycles : saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Encoding is chosen so that bit 0 is "main register valid" and bit 1 is
  // "skid register valid". out_valid and in_ready are then plain flop bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } stage_state_e;

  logic              outValid;
  logic              inReady;
  logic [DATA_W-1:0] headData;
  logic [CTRL_W-1:0] headCtrl;
  logic              accept;
  logic              deliver;

  assign accept  = in_valid && inReady;
  assign deliver = outValid && out_ready;

  generate
    if (SKID != 0) begin : genSkid
      stage_state_e      state_q, state_d;
      logic [DATA_W-1:0] mainData_q, mainData_d;
      logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
      logic [DATA_W-1:0] skidData_q, skidData_d;
      logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;

      // State and payload registers. Reset leaves both entries invalid and
      // the payload cleared.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q    <= EMPTY;
          mainData_q <= '0;
          mainCtrl_q <= '0;
          skidData_q <= '0;
          skidCtrl_q <= '0;
        end else begin
          state_q    <= state_d;
          mainData_q <= mainData_d;
          mainCtrl_q <= mainCtrl_d;
          skidData_q <= skidData_d;
          skidCtrl_q <= skidCtrl_d;
        end
      end

      // Next-state logic. The skid register only catches an entry that
      // arrives while the head is stalled; when the head drains, the skid
      // entry moves forward so arrival order is kept. Flush wins over any
      // accept and leaves the payload untouched, so a discarded input never
      // reaches out_data.
      always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        skidData_d = skidData_q;
        skidCtrl_d = skidCtrl_q;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                state_d    = BUSY;
                mainData_d = in_data;
                mainCtrl_d = in_ctrl;
              end
            end
            BUSY: begin
              if (accept && deliver) begin
                mainData_d = in_data;
                mainCtrl_d = in_ctrl;
              end else if (accept) begin
                state_d    = FULL;
                skidData_d = in_data;
                skidCtrl_d = in_ctrl;
              end else if (deliver) begin
                state_d = EMPTY;
              end
            end
            FULL: begin
              if (deliver) begin
                state_d    = BUSY;
                mainData_d = skidData_q;
                mainCtrl_d = skidCtrl_q;
              end
            end
            default: begin
              state_d = EMPTY;
            end
          endcase
        end
      end

      // in_ready is the inverted skid-valid flop, so there is no
      // combinational path from out_ready.
      assign outValid = state_q[0];
      assign inReady  = ~state_q[1];
      assign headData = mainData_q;
      assign headCtrl = mainCtrl_q;
    end else begin : genNoSkid
      logic              valid_q, valid_d;
      logic [DATA_W-1:0] mainData_q, mainData_d;
      logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;

      // Single register stage.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q    <= 1'b0;
          mainData_q <= '0;
          mainCtrl_q <= '0;
        end else begin
          valid_q    <= valid_d;
          mainData_q <= mainData_d;
          mainCtrl_q <= mainCtrl_d;
        end
      end

      // Whenever the stage can move, the valid bit follows in_valid; the
      // payload only loads on a real accept so out_data holds through
      // bubbles. Flush empties the stage without touching the payload.
      always_comb begin
        valid_d    = valid_q;
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        if (flush) begin
          valid_d = 1'b0;
        end else if (inReady) begin
          valid_d = in_valid;
          if (accept) begin
            mainData_d = in_data;
            mainCtrl_d = in_ctrl;
          end
        end
      end

      // Ready whenever the head is leaving or there is no head at all.
      assign inReady  = out_ready || !valid_q;
      assign outValid = valid_q;
      assign headData = mainData_q;
      assign headCtrl = mainCtrl_q;
    end
  endgenerate

  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  // Back-pressure counter: counts every cycle a valid head is refused and
  // sticks at all-ones. Flush does not clear it; only reset does.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (outValid && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign in_ready     = inReady;
  assign out_valid    = outValid;
  assign out_data     = headData;
  assign out_ctrl     = headCtrl & {CTRL_W{outValid}};
  assign stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Drives three copies of pipe_stage_reg with the same stimulus: a skid copy,
// a single-register copy and a skid copy with a 4-bit stall counter. A queue
// based reference model predicts every output.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 2;

  typedef logic [DW+CW-1:0] entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          inValid;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;
  logic          flush;
  logic          outReady;

  logic          s1InReady, s1OutValid;
  logic [DW-1:0] s1OutData;
  logic [CW-1:0] s1OutCtrl;
  logic [15:0]   s1Stall;

  logic          s0InReady, s0OutValid;
  logic [DW-1:0] s0OutData;
  logic [CW-1:0] s0OutCtrl;
  logic [15:0]   s0Stall;

  logic          sSatInReady, sSatOutValid;
  logic [DW-1:0] sSatOutData;
  logic [CW-1:0] sSatOutCtrl;
  logic [3:0]    sSatStall;

  int nCompared   = 0;
  int nMismatched = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dutSkid (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(s1InReady),
    .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
    .out_valid(s1OutValid), .out_ready(outReady), .out_data(s1OutData),
    .out_ctrl(s1OutCtrl), .stall_cycles(s1Stall)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dutNoSkid (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(s0InReady),
    .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
    .out_valid(s0OutValid), .out_ready(outReady), .out_data(s0OutData),
    .out_ctrl(s0OutCtrl), .stall_cycles(s0Stall)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(sSatInReady),
    .in_data(inData), .in_ctrl(inCtrl), .flush(flush),
    .out_valid(sSatOutValid), .out_ready(outReady), .out_data(sSatOutData),
    .out_ctrl(sSatOutCtrl), .stall_cycles(sSatStall)
  );

  // Reference model: each stage is a FIFO of bounded depth (2 with skid,
  // 1 without). last* remembers the most recent head so out_data can be
  // predicted while the stage is empty.
  entry_t        q1[$];
  entry_t        q0[$];
  logic [15:0]   cnt1   = '0;
  logic [15:0]   cnt0   = '0;
  logic [3:0]    cntSat = '0;
  logic [DW-1:0] last1  = '0;
  logic [DW-1:0] last0  = '0;
  bit            acc1, del1, rdy0;
  entry_t        head;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1.delete();
      q0.delete();
      cnt1   = '0;
      cnt0   = '0;
      cntSat = '0;
      last1  = '0;
      last0  = '0;
    end else begin
      if (q1.size() > 0 && !outReady) begin
        if (cnt1 != 16'hffff) cnt1 = cnt1 + 16'd1;
        if (cntSat != 4'hf) cntSat = cntSat + 4'd1;
      end
      if (q0.size() > 0 && !outReady && cnt0 != 16'hffff) cnt0 = cnt0 + 16'd1;
      acc1 = inValid && (q1.size() < 2);
      del1 = (q1.size() > 0) && outReady;
      rdy0 = outReady || (q0.size() == 0);
      if (flush) begin
        q1.delete();
      end else begin
        if (del1) void'(q1.pop_front());
        if (acc1) q1.push_back({inData, inCtrl});
      end
      if (flush) begin
        q0.delete();
      end else if (rdy0) begin
        if (q0.size() > 0) void'(q0.pop_front());
        if (inValid) q0.push_back({inData, inCtrl});
      end
      if (q1.size() > 0) begin
        head  = q1[0];
        last1 = head[DW+CW-1:CW];
      end
      if (q0.size() > 0) begin
        head  = q0[0];
        last0 = head[DW+CW-1:CW];
      end
    end
  end

  function automatic logic expValid1();
    return q1.size() > 0;
  endfunction

  function automatic logic expValid0();
    return q0.size() > 0;
  endfunction

  function automatic logic expReady1();
    return q1.size() < 2;
  endfunction

  function automatic logic expReady0();
    return outReady || (q0.size() == 0);
  endfunction

  function automatic logic [CW-1:0] expCtrl1();
    entry_t e;
    if (q1.size() == 0) return '0;
    e = q1[0];
    return e[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] expCtrl0();
    entry_t e;
    if (q0.size() == 0) return '0;
    e = q0[0];
    return e[CW-1:0];
  endfunction

  // Moves from one negedge+1 point to the next, passing one rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inCtrl   = '0;
    flush    = 1'b0;
    outReady = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    rst = 1'b0;
    step();
    nCompared++;
    if ({s1OutValid, s1InReady, s1OutCtrl, s1OutData, s1Stall} !== {1'b1 ^ 1'b1, 1'b1, 2'b00, 16'h0, 16'h0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_skid got v=%0b r=%0b c=%0h d=%0h s=%0d exp v=0 r=1 c=0 d=0 s=0",
               s1OutValid, s1InReady, s1OutCtrl, s1OutData, s1Stall);
    end
    nCompared++;
    if ({s0OutValid, s0InReady, s0OutCtrl, s0OutData, s0Stall} !== {1'b0, 1'b1, 2'b00, 16'h0, 16'h0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_noskid got v=%0b r=%0b c=%0h d=%0h s=%0d exp v=0 r=1 c=0 d=0 s=0",
               s0OutValid, s0InReady, s0OutCtrl, s0OutData, s0Stall);
    end
    nCompared++;
    if ({sSatOutValid, sSatInReady, sSatOutCtrl, sSatStall} !== {1'b0, 1'b1, 2'b00, 4'h0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_sat got v=%0b r=%0b c=%0h s=%0d exp v=0 r=1 c=0 s=0",
               sSatOutValid, sSatInReady, sSatOutCtrl, sSatStall);
    end
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    doReset();
    for (int i = 1; i <= 8; i++) begin
      inValid  = 1'b1;
      inData   = DW'(i);
      inCtrl   = CW'(i);
      outReady = 1'b1;
      #1;
      nCompared++;
      if ({s1InReady, s0InReady} !== 2'b11) begin
        nMismatched++;
        $display("[TB] FAIL stream_ready i=%0d got skid=%0b noskid=%0b exp 1 1", i, s1InReady, s0InReady);
      end
      step();
      nCompared++;
      if (s1OutValid !== 1'b1 || s1OutData !== DW'(i)) begin
        nMismatched++;
        $display("[TB] FAIL stream_skid i=%0d got v=%0b d=%0h exp v=1 d=%0h", i, s1OutValid, s1OutData, i);
      end
      nCompared++;
      if (s0OutValid !== 1'b1 || s0OutData !== DW'(i)) begin
        nMismatched++;
        $display("[TB] FAIL stream_noskid i=%0d got v=%0b d=%0h exp v=1 d=%0h", i, s0OutValid, s0OutData, i);
      end
    end
    inValid = 1'b0;
    step();
    nCompared++;
    if ({s1OutValid, s0OutValid} !== 2'b00 || s1Stall !== 16'd0) begin
      nMismatched++;
      $display("[TB] FAIL stream_end got v1=%0b v0=%0b stall=%0d exp 0 0 0", s1OutValid, s0OutValid, s1Stall);
    end
  endtask

  task automatic test_back_pressure();
    doReset();
    inValid  = 1'b1;
    inData   = 16'h0A0A;
    inCtrl   = 2'b01;
    outReady = 1'b0;
    step();
    inData = 16'h0B0B;
    inCtrl = 2'b10;
    step();
    nCompared++;
    if ({s1InReady, s1OutValid, s1OutCtrl, s1OutData} !== {1'b0, 1'b1, 2'b01, 16'h0A0A}) begin
      nMismatched++;
      $display("[TB] FAIL bp_full got r=%0b v=%0b c=%0h d=%0h exp r=0 v=1 c=1 d=0a0a",
               s1InReady, s1OutValid, s1OutCtrl, s1OutData);
    end
    inValid = 1'b0;
    repeat (3) step();
    nCompared++;
    if (s1Stall !== 16'd4 || s0Stall !== 16'd4) begin
      nMismatched++;
      $display("[TB] FAIL bp_stall got skid=%0d noskid=%0d exp 4 4", s1Stall, s0Stall);
    end
    outReady = 1'b1;
    #1;
    nCompared++;
    if (s1OutValid !== 1'b1 || s1OutData !== 16'h0A0A || s0InReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL bp_headA got v=%0b d=%0h r0=%0b exp v=1 d=0a0a r0=1", s1OutValid, s1OutData, s0InReady);
    end
    step();
    nCompared++;
    if ({s1OutValid, s1InReady, s1OutData, s0OutValid} !== {1'b1, 1'b1, 16'h0B0B, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL bp_headB got v=%0b r=%0b d=%0h v0=%0b exp v=1 r=1 d=0b0b v0=0",
               s1OutValid, s1InReady, s1OutData, s0OutValid);
    end
    step();
    nCompared++;
    if (s1OutValid !== 1'b0 || s1Stall !== 16'd4) begin
      nMismatched++;
      $display("[TB] FAIL bp_drained got v=%0b stall=%0d exp v=0 stall=4", s1OutValid, s1Stall);
    end
  endtask

  task automatic test_flush();
    doReset();
    inValid  = 1'b1;
    inData   = 16'h00A1;
    inCtrl   = 2'b01;
    outReady = 1'b0;
    step();
    inData = 16'h00B2;
    inCtrl = 2'b10;
    step();
    nCompared++;
    if (s1InReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL flush_prefull got r=%0b exp 0", s1InReady);
    end
    inData = 16'h00C3;
    inCtrl = 2'b11;
    flush  = 1'b1;
    step();
    nCompared++;
    if ({s1OutValid, s1OutCtrl, s1OutData, s1InReady} !== {1'b0, 2'b00, 16'h00A1, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL flush_full_skid got v=%0b c=%0h d=%0h r=%0b exp v=0 c=0 d=00a1 r=1",
               s1OutValid, s1OutCtrl, s1OutData, s1InReady);
    end
    nCompared++;
    if ({s0OutValid, s0OutCtrl, s0OutData} !== {1'b0, 2'b00, 16'h00A1}) begin
      nMismatched++;
      $display("[TB] FAIL flush_noskid got v=%0b c=%0h d=%0h exp v=0 c=0 d=00a1", s0OutValid, s0OutCtrl, s0OutData);
    end
    flush   = 1'b0;
    inValid = 1'b0;
    inData  = 16'h00A1;
    inCtrl  = 2'b01;
    inValid = 1'b1;
    step();
    inData = 16'h00C3;
    inCtrl = 2'b11;
    flush  = 1'b1;
    #1;
    nCompared++;
    if (s1InReady !== 1'b1 || s1OutValid !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL flush_busy_pre got r=%0b v=%0b exp r=1 v=1", s1InReady, s1OutValid);
    end
    step();
    flush    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if ({s1OutValid, s1OutCtrl, s0OutValid, s0OutCtrl} !== 6'b0) begin
        nMismatched++;
        $display("[TB] FAIL flush_no_c i=%0d got v1=%0b c1=%0h v0=%0b c0=%0h exp all 0",
                 i, s1OutValid, s1OutCtrl, s0OutValid, s0OutCtrl);
      end
      step();
    end
  endtask

  task automatic test_bubble();
    flush    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      inValid  = 1'b0;
      inCtrl   = 2'b11;
      inData   = DW'($urandom);
      outReady = (i % 2 == 0);
      step();
      nCompared++;
      if ({s1OutValid, s1OutCtrl, s0OutValid, s0OutCtrl} !== 6'b0) begin
        nMismatched++;
        $display("[TB] FAIL bubble i=%0d got v1=%0b c1=%0h v0=%0b c0=%0h exp all 0",
                 i, s1OutValid, s1OutCtrl, s0OutValid, s0OutCtrl);
      end
    end
  endtask

  task automatic test_saturation();
    doReset();
    inValid  = 1'b1;
    inData   = 16'h0005;
    inCtrl   = 2'b01;
    outReady = 1'b0;
    step();
    inValid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      nCompared++;
      if (sSatStall !== 4'((k > 15) ? 15 : k) || s1Stall !== 16'(k)) begin
        nMismatched++;
        $display("[TB] FAIL sat k=%0d got sat=%0d wide=%0d exp sat=%0d wide=%0d",
                 k, sSatStall, s1Stall, (k > 15) ? 15 : k, k);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    flush    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    step();
    flush   = 1'b0;
    inValid = 1'b1;
    inData  = 16'h1111;
    inCtrl  = 2'b11;
    step();
    inData = 16'h2222;
    step();
    inValid = 1'b0;
    nCompared++;
    if (s1OutCtrl !== 2'b11 || s1InReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midrst_pre got c=%0h r=%0b exp c=3 r=0", s1OutCtrl, s1InReady);
    end
    #1;
    rst = 1'b0;
    #1;
    nCompared++;
    if ({s1OutValid, s1OutCtrl, s1InReady, s1Stall} !== {1'b0, 2'b00, 1'b1, 16'h0}) begin
      nMismatched++;
      $display("[TB] FAIL midrst_skid got v=%0b c=%0h r=%0b s=%0d exp v=0 c=0 r=1 s=0",
               s1OutValid, s1OutCtrl, s1InReady, s1Stall);
    end
    nCompared++;
    if ({sSatOutValid, sSatOutCtrl, sSatInReady, sSatStall} !== {1'b0, 2'b00, 1'b1, 4'h0}) begin
      nMismatched++;
      $display("[TB] FAIL midrst_sat got v=%0b c=%0h r=%0b s=%0d exp v=0 c=0 r=1 s=0",
               sSatOutValid, sSatOutCtrl, sSatInReady, sSatStall);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_random();
    doReset();
    for (int n = 0; n < 400; n++) begin
      inValid  = ($urandom % 4) != 0;
      inData   = DW'($urandom);
      inCtrl   = CW'($urandom);
      flush    = ($urandom % 16) == 0;
      outReady = ($urandom % 3) != 0;
      #1;
      nCompared++;
      if ({s1OutValid, s1InReady, s1OutCtrl} !== {expValid1(), expReady1(), expCtrl1()}) begin
        nMismatched++;
        $display("[TB] FAIL rnd_skid_ctl n=%0d got v=%0b r=%0b c=%0h exp v=%0b r=%0b c=%0h",
                 n, s1OutValid, s1InReady, s1OutCtrl, expValid1(), expReady1(), expCtrl1());
      end
      nCompared++;
      if (s1OutData !== last1 || s1Stall !== cnt1) begin
        nMismatched++;
        $display("[TB] FAIL rnd_skid_data n=%0d got d=%0h s=%0d exp d=%0h s=%0d", n, s1OutData, s1Stall, last1, cnt1);
      end
      nCompared++;
      if ({s0OutValid, s0InReady, s0OutCtrl} !== {expValid0(), expReady0(), expCtrl0()}) begin
        nMismatched++;
        $display("[TB] FAIL rnd_noskid_ctl n=%0d got v=%0b r=%0b c=%0h exp v=%0b r=%0b c=%0h",
                 n, s0OutValid, s0InReady, s0OutCtrl, expValid0(), expReady0(), expCtrl0());
      end
      nCompared++;
      if (s0OutData !== last0 || s0Stall !== cnt0) begin
        nMismatched++;
        $display("[TB] FAIL rnd_noskid_data n=%0d got d=%0h s=%0d exp d=%0h s=%0d", n, s0OutData, s0Stall, last0, cnt0);
      end
      nCompared++;
      if ({sSatOutValid, sSatInReady, sSatOutCtrl, sSatOutData, sSatStall} !==
          {expValid1(), expReady1(), expCtrl1(), last1, cntSat}) begin
        nMismatched++;
        $display("[TB] FAIL rnd_sat n=%0d got v=%0b r=%0b c=%0h d=%0h s=%0d exp v=%0b r=%0b c=%0h d=%0h s=%0d",
                 n, sSatOutValid, sSatInReady, sSatOutCtrl, sSatOutData, sSatStall,
                 expValid1(), expReady1(), expCtrl1(), last1, cntSat);
      end
      step();
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    rst      = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inCtrl   = '0;
    flush    = 1'b0;
    outReady = 1'b0;
    step();
    $display("[TB] starting pipe_stage_reg scenarios");
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_reset_mid_stream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
